fifo_wr_arbiter: RTL and testbench

Round-robin write-port arbiter that shares one single-clock FIFO's write side (`wr`, `din`, `full`) between N_REQ producers. Each producer offers data through a valid/ready handshake. The arbiter grants one producer at a time for a bounded burst and drives the FIFO write strobe and data. It sits directly in front of the `fifo` instance; the FIFO read side is untouched.

---
 rtl/fifo_wr_arbiter.sv | 127 ++++++++++++
 tb/tb_fifo_wr_arbiter.sv | 458 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among N_REQ valid/ready producers.
// Each grant lasts until req_last, BURST beats, or the owner withdraws valid.
module fifo_wr_arbiter #(
   parameter int unsigned N_REQ   = 4,
   parameter int unsigned N_REQ_l = $clog2(N_REQ),
   parameter int unsigned WIDTH   = 8,
   parameter int unsigned BURST   = 4
) (
   input  logic                   clock,
   input  logic                   reset_n,
   input  logic [N_REQ-1:0]       req_valid,
   input  logic [N_REQ-1:0]       req_last,
   input  logic [N_REQ*WIDTH-1:0] req_data,
   output logic [N_REQ-1:0]       req_ready,
   output logic [N_REQ-1:0]       grant,
   output logic                   busy,
   output logic                   fifo_wr,
   output logic [WIDTH-1:0]       fifo_din,
   input  logic                   fifo_full
);

   localparam int unsigned CntW = $clog2(BURST) + 1;

   localparam logic [0:0] StIdle  = 1'b0;
   localparam logic [0:0] StGrant = 1'b1;

   localparam logic [N_REQ_l-1:0] PtrRst  = N_REQ_l'(N_REQ - 1);
   localparam logic [CntW-1:0]    LastCnt = CntW'(BURST - 1);

   logic [0:0]         state_q, state_d;
   logic [N_REQ-1:0]   grant_q, grant_d;
   logic [N_REQ_l-1:0] gidx_q, gidx_d;
   logic [N_REQ_l-1:0] ptr_q, ptr_d;
   logic [CntW-1:0]    cnt_q, cnt_d;

   logic               sel_found;
   logic [N_REQ_l-1:0] sel_idx;
   logic [N_REQ_l-1:0] cand;
   logic [WIDTH-1:0]   sel_data;
   logic               in_grant;
   logic               beat;

   // Scan from farthest to nearest so the first valid bit after ptr wins.
   always_comb begin
      sel_found = 1'b0;
      sel_idx   = '0;
      cand      = '0;
      for (int k = int'(N_REQ); k >= 1; k--) begin
         cand = N_REQ_l'((int'(ptr_q) + k) % int'(N_REQ));
         if (req_valid[cand]) begin
            sel_found = 1'b1;
            sel_idx   = cand;
         end
      end
   end

   always_comb begin
      sel_data = '0;
      for (int i = 0; i < int'(N_REQ); i++) begin
         if (gidx_q == N_REQ_l'(i)) begin
            sel_data = req_data[i*WIDTH +: WIDTH];
         end
      end
   end

   assign in_grant  = (state_q == StGrant);
   assign beat      = in_grant & req_valid[gidx_q] & ~fifo_full;
   assign fifo_wr   = beat;
   assign req_ready = grant_q & {N_REQ{beat}};
   assign fifo_din  = in_grant ? sel_data : '0;
   assign grant     = grant_q;
   assign busy      = in_grant;

   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      gidx_d  = gidx_q;
      ptr_d   = ptr_q;
      cnt_d   = cnt_q;
      case (state_q)
         StIdle: begin
            if (sel_found) begin
               state_d          = StGrant;
               gidx_d           = sel_idx;
               grant_d          = '0;
               grant_d[sel_idx] = 1'b1;
               cnt_d            = '0;
            end
         end
         StGrant: begin
            if (!req_valid[gidx_q]) begin
               state_d = StIdle;
               ptr_d   = gidx_q;
               grant_d = '0;
            end else if (beat) begin
               cnt_d = cnt_q + CntW'(1);
               if (req_last[gidx_q] || (cnt_q == LastCnt)) begin
                  state_d = StIdle;
                  ptr_d   = gidx_q;
                  grant_d = '0;
               end
            end
         end
         default: begin
            state_d = StIdle;
            grant_d = '0;
         end
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= StIdle;
         grant_q <= '0;
         gidx_q  <= '0;
         ptr_q   <= PtrRst;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         gidx_q  <= gidx_d;
         ptr_q   <= ptr_d;
         cnt_q   <= cnt_d;
      end
   end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: directed scenarios plus randomized traffic into a modelled
// 16-deep FIFO, all checked against a transaction-level round-robin reference.
module tb_fifo_wr_arbiter;

   localparam int N = 4;
   localparam int W = 8;
   localparam int B = 4;

   logic           clock = 1'b0;
   logic           reset_n = 1'b0;
   logic [N-1:0]   req_valid = '0;
   logic [N-1:0]   req_last = '0;
   logic [N*W-1:0] req_data;
   logic [W-1:0]   dat [N];
   logic [N-1:0]   req_ready, grant;
   logic           busy, fifo_wr;
   logic [W-1:0]   fifo_din;
   logic           fifo_full = 1'b0;

   int total = 0;
   int bad   = 0;

   // Reference: current owner (-1 idle), last served index, beats in current grant.
   int           m_owner, m_ptr, m_cnt;
   logic [N-1:0] e_grant, e_ready;
   logic         e_wr, e_busy;
   logic [W-1:0] e_din;

   fifo_wr_arbiter #(.N_REQ(N), .WIDTH(W), .BURST(B)) dut (
      .clock     (clock),
      .reset_n   (reset_n),
      .req_valid (req_valid),
      .req_last  (req_last),
      .req_data  (req_data),
      .req_ready (req_ready),
      .grant     (grant),
      .busy      (busy),
      .fifo_wr   (fifo_wr),
      .fifo_din  (fifo_din),
      .fifo_full (fifo_full)
   );

   always #5 clock = ~clock;

   always_comb begin
      req_data = '0;
      for (int i = 0; i < N; i++) req_data[i*W +: W] = dat[i];
   end

   task automatic model_reset();
      m_owner = -1;
      m_ptr   = N - 1;
      m_cnt   = 0;
   endtask

   task automatic model_eval();
      e_busy  = (m_owner >= 0);
      e_wr    = 1'b0;
      e_grant = '0;
      e_din   = '0;
      if (e_busy) begin
         e_wr    = req_valid[m_owner] && !fifo_full;
         e_grant = N'(1) << m_owner;
         e_din   = dat[m_owner];
      end
      e_ready = e_wr ? e_grant : '0;
   endtask

   task automatic model_step();
      if (m_owner < 0) begin
         for (int k = 1; k <= N; k++) begin
            int c = (m_ptr + k) % N;
            if (req_valid[c]) begin
               m_owner = c;
               m_cnt   = 0;
               break;
            end
         end
      end else if (!req_valid[m_owner]) begin
         m_ptr   = m_owner;
         m_owner = -1;
      end else if (e_wr) begin
         m_cnt++;
         if (req_last[m_owner] || m_cnt == B) begin
            m_ptr   = m_owner;
            m_owner = -1;
         end
      end
   endtask

   // Advance one clock from a falling edge to the next falling edge.
   task automatic cycle();
      @(posedge clock);
      model_step();
      @(negedge clock);
   endtask

   task automatic do_reset();
      reset_n   = 1'b0;
      req_valid = '0;
      req_last  = '0;
      fifo_full = 1'b0;
      model_reset();
      @(negedge clock);
      @(negedge clock);
      reset_n = 1'b1;
   endtask

   task automatic test_reset();
      for (int i = 0; i < N; i++) dat[i] = 8'hA0 + 8'(i);
      model_reset();
      #1;
      total++;
      if ({grant, req_ready, busy, fifo_wr, fifo_din} !== '0) begin
         bad++;
         $display("FAIL reset_outs: got g=%b r=%b b=%b w=%b d=%h want all zero",
                  grant, req_ready, busy, fifo_wr, fifo_din);
      end
      req_valid = '1;
      @(posedge clock);
      #1;
      total++;
      if ({grant, req_ready, busy, fifo_wr, fifo_din} !== '0) begin
         bad++;
         $display("FAIL reset_hold: got g=%b r=%b b=%b w=%b d=%h want all zero",
                  grant, req_ready, busy, fifo_wr, fifo_din);
      end
      @(negedge clock);
      req_valid = '0;
      reset_n   = 1'b1;
   endtask

   task automatic test_single_burst();
      int b = 0;
      int first_wr = -1;
      int last_wr = -1;
      logic [W-1:0] got[$];
      for (int cyc = 0; cyc < 7; cyc++) begin
         req_valid = (b < 4) ? 4'b0100 : 4'b0000;
         req_last  = (b == 3) ? 4'b0100 : 4'b0000;
         dat[2]    = 8'(8'h10 + b);
         #1;
         model_eval();
         total++;
         if ({grant, req_ready, busy, fifo_wr, fifo_din} !== {e_grant, e_ready, e_busy, e_wr, e_din}) begin
            bad++;
            $display("FAIL burst c%0d: got g=%b r=%b b=%b w=%b d=%h want g=%b r=%b b=%b w=%b d=%h",
                     cyc, grant, req_ready, busy, fifo_wr, fifo_din, e_grant, e_ready, e_busy, e_wr, e_din);
         end
         if (cyc == 1) begin
            total++;
            if (grant !== 4'b0100) begin
               bad++;
               $display("FAIL burst_grant: got %b want 0100", grant);
            end
         end
         if (fifo_wr === 1'b1) begin
            got.push_back(fifo_din);
            if (first_wr < 0) first_wr = cyc;
            last_wr = cyc;
         end
         if (e_ready[2]) b++;
         cycle();
      end
      total++;
      if (got.size() != 4 || (last_wr - first_wr) != 3) begin
         bad++;
         $display("FAIL burst_count: got %0d beats span %0d want 4 beats span 3",
                  got.size(), last_wr - first_wr);
      end
      for (int i = 0; i < got.size(); i++) begin
         total++;
         if (got[i] !== 8'(8'h10 + i)) begin
            bad++;
            $display("FAIL burst_data%0d: got %h want %h", i, got[i], 8'(8'h10 + i));
         end
      end
      // ptr now 2: with 0 and 3 both requesting, 3 must win.
      req_valid = 4'b1001;
      req_last  = '0;
      #1;
      model_eval();
      cycle();
      req_valid = '0;
      #1;
      model_eval();
      total++;
      if (grant !== 4'b1000 || e_grant !== 4'b1000) begin
         bad++;
         $display("FAIL burst_ptr: got %b want 1000", grant);
      end
      cycle();
      #1;
      model_eval();
      total++;
      if (busy !== 1'b0 || e_busy !== 1'b0) begin
         bad++;
         $display("FAIL burst_withdraw: got busy=%b want 0", busy);
      end
   endtask

   task automatic test_fairness();
      logic [N-1:0] order[$];
      logic [N-1:0] want [6] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};
      logic [N-1:0] prev = '0;
      int beats20 = 0;
      int nb [N] = '{default: 0};
      do_reset();
      for (int cyc = 0; cyc < 27; cyc++) begin
         req_valid = '1;
         req_last  = '0;
         for (int i = 0; i < N; i++) dat[i] = 8'(i * 16 + nb[i]);
         #1;
         model_eval();
         total++;
         if ({grant, req_ready, busy, fifo_wr, fifo_din} !== {e_grant, e_ready, e_busy, e_wr, e_din}) begin
            bad++;
            $display("FAIL fair c%0d: got g=%b r=%b b=%b w=%b d=%h want g=%b r=%b b=%b w=%b d=%h",
                     cyc, grant, req_ready, busy, fifo_wr, fifo_din, e_grant, e_ready, e_busy, e_wr, e_din);
         end
         if (grant != '0 && grant != prev) order.push_back(grant);
         prev = grant;
         if (cyc < 20 && fifo_wr === 1'b1) beats20++;
         for (int i = 0; i < N; i++) if (e_ready[i]) nb[i]++;
         cycle();
      end
      total++;
      if (beats20 != 16) begin
         bad++;
         $display("FAIL fair_throughput: got %0d beats in 20 cycles want 16", beats20);
      end
      for (int i = 0; i < 6; i++) begin
         total++;
         if (i >= order.size() || order[i] !== want[i]) begin
            bad++;
            $display("FAIL fair_order%0d: got %b want %b", i,
                     (i < order.size()) ? order[i] : 4'bxxxx, want[i]);
         end
      end
   endtask

   task automatic test_full_stall();
      int b = 0;
      int stall = 0;
      int wrs = 0;
      do_reset();
      for (int cyc = 0; cyc < 14; cyc++) begin
         req_valid = (b < 4) ? 4'b0010 : 4'b0000;
         req_last  = '0;
         dat[1]    = 8'(8'h20 + b);
         fifo_full = (b == 2 && stall < 5);
         #1;
         model_eval();
         total++;
         if ({grant, req_ready, busy, fifo_wr, fifo_din} !== {e_grant, e_ready, e_busy, e_wr, e_din}) begin
            bad++;
            $display("FAIL stall c%0d: got g=%b r=%b b=%b w=%b d=%h want g=%b r=%b b=%b w=%b d=%h",
                     cyc, grant, req_ready, busy, fifo_wr, fifo_din, e_grant, e_ready, e_busy, e_wr, e_din);
         end
         if (fifo_full) begin
            stall++;
            total++;
            if (fifo_wr !== 1'b0 || req_ready !== 4'b0000 || grant !== 4'b0010) begin
               bad++;
               $display("FAIL stall_hold: got w=%b r=%b g=%b want w=0 r=0000 g=0010",
                        fifo_wr, req_ready, grant);
            end
         end
         if (fifo_wr === 1'b1) wrs++;
         if (e_ready[1]) b++;
         cycle();
      end
      fifo_full = 1'b0;
      total++;
      if (wrs != 4 || stall != 5) begin
         bad++;
         $display("FAIL stall_total: got %0d beats %0d stall cycles want 4 and 5", wrs, stall);
      end
   endtask

   task automatic test_early_term();
      int b;
      int wrs;
      do_reset();
      for (int ph = 0; ph < 2; ph++) begin
         int req = (ph == 0) ? 3 : 0;
         int nbeat = (ph == 0) ? 2 : 1;
         b   = 0;
         wrs = 0;
         for (int cyc = 0; cyc < 5; cyc++) begin
            req_valid = (b < nbeat) ? N'(1) << req : '0;
            req_last  = (ph == 0 && b == 1) ? 4'b1000 : 4'b0000;
            dat[req]  = 8'(8'h30 + ph * 16 + b);
            #1;
            model_eval();
            total++;
            if ({grant, req_ready, busy, fifo_wr, fifo_din} !== {e_grant, e_ready, e_busy, e_wr, e_din}) begin
               bad++;
               $display("FAIL early%0d c%0d: got g=%b r=%b b=%b w=%b d=%h want g=%b r=%b b=%b w=%b d=%h",
                        ph, cyc, grant, req_ready, busy, fifo_wr, fifo_din, e_grant, e_ready, e_busy, e_wr, e_din);
            end
            if (cyc == nbeat + 1 + ph) begin
               total++;
               if (busy !== 1'b0) begin
                  bad++;
                  $display("FAIL early%0d_release: got busy=%b want 0", ph, busy);
               end
            end
            if (fifo_wr === 1'b1) wrs++;
            if (e_ready[req]) b++;
            cycle();
         end
         total++;
         if (wrs != nbeat) begin
            bad++;
            $display("FAIL early%0d_beats: got %0d want %0d", ph, wrs, nbeat);
         end
      end
      // ptr now 0: requester 1 beats requester 0.
      req_valid = 4'b0011;
      req_last  = '0;
      #1;
      model_eval();
      cycle();
      req_valid = '0;
      #1;
      model_eval();
      total++;
      if (grant !== 4'b0010) begin
         bad++;
         $display("FAIL early_ptr: got %b want 0010", grant);
      end
      cycle();
   endtask

   task automatic test_reset_midburst();
      int b = 0;
      bit hit = 0;
      do_reset();
      for (int cyc = 0; cyc < 10; cyc++) begin
         req_valid = 4'b0010;
         req_last  = '0;
         dat[1]    = 8'(8'h50 + b);
         #1;
         model_eval();
         if (b == 2 && fifo_wr === 1'b1) begin
            hit     = 1;
            reset_n = 1'b0;
            #1;
            total++;
            if ({fifo_wr, grant, busy, req_ready} !== '0) begin
               bad++;
               $display("FAIL midreset_drop: got w=%b g=%b b=%b r=%b want all zero",
                        fifo_wr, grant, busy, req_ready);
            end
            break;
         end
         if (e_ready[1]) b++;
         cycle();
      end
      total++;
      if (!hit) begin
         bad++;
         $display("FAIL midreset_reach: got %0d beats want 3rd beat within 10 cycles", b);
      end
      model_reset();
      req_valid = '1;
      @(negedge clock);
      reset_n = 1'b1;
      #1;
      model_eval();
      cycle();
      #1;
      model_eval();
      total++;
      if (grant !== 4'b0001 || e_grant !== 4'b0001) begin
         bad++;
         $display("FAIL midreset_first: got %b want 0001", grant);
      end
   endtask

   task automatic test_random_interop();
      logic [W-1:0] fq[$];
      logic [W-1:0] sb[$];
      logic [W-1:0] rd, ex;
      logic [N-1:0] acc = '0;
      do_reset();
      for (int cyc = 0; cyc < 600; cyc++) begin
         fifo_full = (fq.size() >= 16);
         for (int i = 0; i < N; i++) begin
            if (!req_valid[i] || acc[i]) begin
               req_valid[i] = ($urandom_range(0, 2) != 0);
               req_last[i]  = ($urandom_range(0, 3) == 0);
               dat[i]       = 8'($urandom);
            end
         end
         #1;
         model_eval();
         total++;
         if ({grant, req_ready, busy, fifo_wr, fifo_din} !== {e_grant, e_ready, e_busy, e_wr, e_din}) begin
            bad++;
            $display("FAIL rand c%0d: got g=%b r=%b b=%b w=%b d=%h want g=%b r=%b b=%b w=%b d=%h",
                     cyc, grant, req_ready, busy, fifo_wr, fifo_din, e_grant, e_ready, e_busy, e_wr, e_din);
         end
         total++;
         if (fifo_wr === 1'b1 && fifo_full) begin
            bad++;
            $display("FAIL rand_overlap c%0d: got wr=1 with full=1 want wr=0", cyc);
         end
         if (fifo_wr === 1'b1) fq.push_back(fifo_din);
         if (e_wr) sb.push_back(e_din);
         acc = e_ready;
         if (fq.size() > 0 && $urandom_range(0, 3) == 0) begin
            rd = fq.pop_front();
            ex = (sb.size() > 0) ? sb.pop_front() : 8'hxx;
            total++;
            if (rd !== ex) begin
               bad++;
               $display("FAIL rand_order c%0d: got %h want %h", cyc, rd, ex);
            end
         end
         cycle();
      end
      while (fq.size() > 0) begin
         rd = fq.pop_front();
         ex = (sb.size() > 0) ? sb.pop_front() : 8'hxx;
         total++;
         if (rd !== ex) begin
            bad++;
            $display("FAIL rand_drain: got %h want %h", rd, ex);
         end
      end
      total++;
      if (sb.size() != 0) begin
         bad++;
         $display("FAIL rand_left: got %0d unmatched expected beats want 0", sb.size());
      end
   endtask

   initial begin
      test_reset();
      test_single_burst();
      test_fairness();
      test_full_stall();
      test_early_term();
      test_reset_midburst();
      test_random_interop();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
